uart_autobaud: RTL and testbench

//  Configures uart_rx: measures the bit period of a 0x55 ('U') sync character on rxd and

---
 rtl/uart_autobaud.sv | 168 ++++++++++++++++
 tb/tb_uart_autobaud.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud.sv
// Auto-baud detector: times a 0x55 sync character on rxd and derives the uart prescale
// (clk cycles per bit / 8) from eight bit periods.
module uart_autobaud #(
  parameter int unsigned CNT_WIDTH = 24,
  parameter int unsigned TIMEOUT   = 1048575,
  parameter int unsigned TOL_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        start,
  output logic [15:0] prescale,
  output logic        prescale_valid,
  output logic        locked,
  output logic        error,
  output logic        busy
);

  localparam int unsigned W1 = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CntOne     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TimeoutCnt = CNT_WIDTH'(TIMEOUT);
  localparam logic [W1-1:0]        Round      = W1'(32);

  typedef enum logic [1:0] {StIdle, StArmed, StMeasure} state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [CNT_WIDTH-1:0] total_q, total_d;
  logic [CNT_WIDTH-1:0] interval_q, interval_d;
  logic [CNT_WIDTH-1:0] t0_q, t0_d;
  logic [3:0]           edges_q, edges_d;
  logic [15:0]          prescale_q, prescale_d;
  logic                 pv_q, pv_d;
  logic                 locked_q, locked_d;
  logic                 error_q, error_d;

  logic                 fall, line_edge, fail;
  logic [CNT_WIDTH-1:0] tol, total_inc, interval_inc;
  logic [W1-1:0]        hi_bound, lo_bound, ivl_w, p_wide;
  logic                 p_zero, p_big;

  assign fall      = prev_q & ~sync2_q;
  assign line_edge = prev_q ^ sync2_q;

  assign tol      = t0_q >> TOL_SHIFT;
  assign hi_bound = {1'b0, t0_q} + {1'b0, tol};
  assign lo_bound = {1'b0, t0_q} - {1'b0, tol};
  assign ivl_w    = {1'b0, interval_q};

  assign p_wide = ({1'b0, total_q} + Round) >> 6;
  assign p_zero = (p_wide == '0);
  assign p_big  = ((p_wide >> 16) != '0);

  assign total_inc    = (&total_q)    ? total_q    : total_q + CntOne;
  assign interval_inc = (&interval_q) ? interval_q : interval_q + CntOne;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      total_q    <= '0;
      interval_q <= '0;
      t0_q       <= '0;
      edges_q    <= '0;
      prescale_q <= '0;
      pv_q       <= 1'b0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      total_q    <= total_d;
      interval_q <= interval_d;
      t0_q       <= t0_d;
      edges_q    <= edges_d;
      prescale_q <= prescale_d;
      pv_q       <= pv_d;
      locked_q   <= locked_d;
      error_q    <= error_d;
    end
  end

  // total_q/interval_q always hold the index of the current cycle, where the reference
  // cycle (the start fall, or the latest edge) is cycle 0.
  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    interval_d = interval_q;
    t0_d       = t0_q;
    edges_d    = edges_q;
    prescale_d = prescale_q;
    pv_d       = 1'b0;
    locked_d   = locked_q;
    error_d    = 1'b0;
    fail       = 1'b0;

    if (start) begin
      locked_d   = 1'b0;
      total_d    = '0;
      interval_d = '0;
      t0_d       = '0;
      edges_d    = '0;
      state_d    = StArmed;
    end else begin
      unique case (state_q)
        StIdle: ;
        StArmed: begin
          if (fall) begin
            state_d    = StMeasure;
            total_d    = CntOne;
            interval_d = CntOne;
            edges_d    = '0;
          end
        end
        StMeasure: begin
          total_d    = total_inc;
          interval_d = interval_inc;
          if (edges_q == 4'd0) begin
            if (interval_q == TimeoutCnt) begin
              fail = 1'b1;
            end else if (line_edge) begin
              t0_d       = interval_q;
              edges_d    = 4'd1;
              interval_d = CntOne;
            end
          end else begin
            if (ivl_w > hi_bound) begin
              fail = 1'b1;
            end else if (line_edge) begin
              if (ivl_w < lo_bound) begin
                fail = 1'b1;
              end else if (edges_q == 4'd7) begin
                if (p_zero || p_big) begin
                  fail = 1'b1;
                end else begin
                  prescale_d = p_wide[15:0];
                  pv_d       = 1'b1;
                  locked_d   = 1'b1;
                  state_d    = StIdle;
                end
              end else begin
                edges_d    = edges_q + 4'd1;
                interval_d = CntOne;
              end
            end
          end
          if (fail) begin
            error_d  = 1'b1;
            locked_d = 1'b0;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign prescale       = prescale_q;
  assign prescale_valid = pv_q;
  assign locked         = locked_q;
  assign error          = error_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: clean, slow, jittered and malformed sync characters,
// timeout, restart and reset. Inputs driven and outputs sampled on the falling clock edge.
module tb_uart_autobaud;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        start = 1'b0;
  logic [15:0] prescale;
  logic        prescale_valid;
  logic        locked;
  logic        error;
  logic        busy;

  int nvec = 0;
  int nfail = 0;
  int err_cnt = 0;
  int e0;
  int w[8];

  uart_autobaud #(
    .CNT_WIDTH(24),
    .TIMEOUT  (2000),
    .TOL_SHIFT(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .start         (start),
    .prescale      (prescale),
    .prescale_valid(prescale_valid),
    .locked        (locked),
    .error         (error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (error === 1'b1) err_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // Sends start..d6 with the given widths, then the d7 fall (8th edge) and checks that
  // prescale_valid rises exactly three sampled cycles later (2-flop sync + edge flop).
  task automatic send_u(input int wd[8], input logic [15:0] exp_p, input string tag);
    for (int i = 0; i < 8; i++) begin
      rxd = (i % 2 == 1);
      cyc(wd[i]);
    end
    rxd = 1'b0;
    cyc(2);
    check({tag, ".pv_early"}, {31'b0, prescale_valid}, 32'd0);
    cyc(1);
    check({tag, ".pv"}, {31'b0, prescale_valid}, 32'd1);
    check({tag, ".prescale"}, {16'b0, prescale}, {16'b0, exp_p});
    check({tag, ".locked"}, {31'b0, locked}, 32'd1);
    cyc(1);
    check({tag, ".pv_late"}, {31'b0, prescale_valid}, 32'd0);
    check({tag, ".busy"}, {31'b0, busy}, 32'd0);
    cyc(wd[0]);
    rxd = 1'b1;
    cyc(20);
  endtask

  initial begin
    cyc(3);
    check("rst.prescale", {16'b0, prescale}, 32'd0);
    check("rst.pv", {31'b0, prescale_valid}, 32'd0);
    check("rst.locked", {31'b0, locked}, 32'd0);
    check("rst.error", {31'b0, error}, 32'd0);
    check("rst.busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    cyc(5);

    // 1: clean 'U' at 64 clk/bit
    pulse_start();
    check("t1.busy", {31'b0, busy}, 32'd1);
    cyc(3);
    e0 = err_cnt;
    for (int i = 0; i < 8; i++) w[i] = 64;
    send_u(w, 16'd8, "t1");
    check("t1.no_error", err_cnt, e0);

    // 2: 1085 clk/bit, N=8680 -> 136
    pulse_start();
    check("t2.locked_cleared", {31'b0, locked}, 32'd0);
    cyc(3);
    for (int i = 0; i < 8; i++) w[i] = 1085;
    send_u(w, 16'd136, "t2");

    // 3: 64 clk/bit jittered, N=514 -> 8
    pulse_start();
    cyc(3);
    w[0] = 64; w[1] = 54; w[2] = 74; w[3] = 60;
    w[4] = 70; w[5] = 54; w[6] = 74; w[7] = 64;
    send_u(w, 16'd8, "t3");

    // 4: 0x0F -> second interval exceeds 64+16, error at interval 81
    pulse_start();
    cyc(3);
    e0 = err_cnt;
    rxd = 1'b0;
    cyc(64);
    rxd = 1'b1;
    cyc(83);
    check("t4.err_early", {31'b0, error}, 32'd0);
    cyc(1);
    check("t4.err", {31'b0, error}, 32'd1);
    check("t4.locked", {31'b0, locked}, 32'd0);
    check("t4.busy", {31'b0, busy}, 32'd0);
    cyc(1);
    check("t4.err_late", {31'b0, error}, 32'd0);
    check("t4.prescale_kept", {16'b0, prescale}, 32'd8);
    cyc(171);
    rxd = 1'b0;
    cyc(256);
    rxd = 1'b1;
    cyc(20);
    check("t4.one_error", err_cnt, e0 + 1);

    // 5: start bit never ends -> timeout at interval 2000
    pulse_start();
    cyc(3);
    e0 = err_cnt;
    rxd = 1'b0;
    cyc(2002);
    check("t5.err_early", {31'b0, error}, 32'd0);
    check("t5.busy_before", {31'b0, busy}, 32'd1);
    cyc(1);
    check("t5.err", {31'b0, error}, 32'd1);
    cyc(1);
    check("t5.busy", {31'b0, busy}, 32'd0);
    cyc(100);
    rxd = 1'b1;
    cyc(10);
    check("t5.one_error", err_cnt, e0 + 1);
    check("t5.prescale_kept", {16'b0, prescale}, 32'd8);

    // 6a: restart after four edges, then clean 'U' at 32 clk/bit -> 4
    pulse_start();
    cyc(3);
    rxd = 1'b0; cyc(64);
    rxd = 1'b1; cyc(64);
    rxd = 1'b0; cyc(64);
    rxd = 1'b1; cyc(64);
    rxd = 1'b0; cyc(10);
    pulse_start();
    check("t6a.busy", {31'b0, busy}, 32'd1);
    rxd = 1'b1;
    cyc(10);
    check("t6a.locked", {31'b0, locked}, 32'd0);
    for (int i = 0; i < 8; i++) w[i] = 32;
    send_u(w, 16'd4, "t6a");

    // 6b: reset mid-measure
    pulse_start();
    cyc(3);
    e0 = err_cnt;
    rxd = 1'b0; cyc(32);
    rxd = 1'b1; cyc(32);
    rxd = 1'b0; cyc(10);
    check("t6b.busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t6b.prescale", {16'b0, prescale}, 32'd0);
    check("t6b.pv", {31'b0, prescale_valid}, 32'd0);
    check("t6b.locked", {31'b0, locked}, 32'd0);
    check("t6b.error", {31'b0, error}, 32'd0);
    check("t6b.busy", {31'b0, busy}, 32'd0);
    cyc(22);
    rxd = 1'b1;
    cyc(100);
    check("t6b.no_error", err_cnt, e0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
